// File: rtl/cms_trace_stream_receiver.sv
// Trace stream receiver: 2-entry skid FIFO, packet unpack, timestamp rebuild, frame-length check.
// Optional macro CMS_RX_TIMESTAMP_EN builds the absolute timestamp accumulator; otherwise out_abs_ts is 0.
module cms_trace_stream_receiver #(
    parameter int                  XLEN      = 64,
    parameter int                  INSTR_W   = 32,
    parameter int                  TS_W      = 64,
    parameter int                  NO_EVENTS = 39,
    parameter int                  CNT_W     = 7,
    parameter logic [INSTR_W-1:0]  WFI_INSTR = 32'h10500073,
    localparam int                 DATA_W    = NO_EVENTS*CNT_W + NO_EVENTS + XLEN + TS_W + INSTR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic                       s_axis_tlast,
    input  logic [31:0]                tlast_interval,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic [TS_W-1:0]            out_delta,
    output logic [TS_W-1:0]            out_abs_ts,
    output logic [NO_EVENTS-1:0]       out_overflow_map,
    output logic [NO_EVENTS*CNT_W-1:0] out_counters,
    output logic                       out_last,
    output logic [31:0]                pkt_count,
    output logic                       frame_err,
    input  logic                       clr_err
);

    localparam int CNTS_W    = NO_EVENTS * CNT_W;
    localparam int OVF_OFF   = CNTS_W;
    localparam int PC_OFF    = OVF_OFF + NO_EVENTS;
    localparam int DELTA_OFF = PC_OFF + XLEN;
    localparam int INSTR_OFF = DELTA_OFF + TS_W;

    typedef struct packed {
        logic [INSTR_W-1:0]   instr;
        logic [XLEN-1:0]      pc;
        logic [TS_W-1:0]      delta;
        logic [TS_W-1:0]      abs_ts;
        logic [NO_EVENTS-1:0] ovf;
        logic [CNTS_W-1:0]    counters;
        logic                 last;
    } rec_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic              tready_p1;
    logic              vld_p1;
    logic [1:0]        count_p1;
    logic [1:0]        count_d;
    rec_t              head_p1;
    rec_t              skid_p1;
    rec_t              rec_p0;
    logic [CNTS_W-1:0] counters_p0;
    logic [TS_W-1:0]   delta_p0;
    logic [TS_W-1:0]   abs_ts_p0;
    logic              push;
    logic              pop;
    logic [31:0]       pkt_count_p1;
    logic [31:0]       beat_cnt_p1;
    logic [31:0]       beat_cnt_d;
    logic              frame_set;
    logic              frame_err_p1;

    assign push = s_axis_tvalid & tready_p1;
    assign pop  = vld_p1 & out_ready;

    // ---- stage p0: unpack incoming beat ----
    assign delta_p0 = s_axis_tdata[DELTA_OFF +: TS_W];

    // Event 0 arrives in the most significant slot; flip so event i lands at i*CNT_W.
    always_comb begin
        counters_p0 = '0;
        for (int i = 0; i < NO_EVENTS; i++) begin
            counters_p0[i*CNT_W +: CNT_W] = s_axis_tdata[(NO_EVENTS-1-i)*CNT_W +: CNT_W];
        end
    end

`ifdef CMS_RX_TIMESTAMP_EN
    logic [TS_W-1:0] abs_acc_p1;

    assign abs_ts_p0 = abs_acc_p1 + delta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_acc_p1 <= '0;
        end else if (push) begin
            abs_acc_p1 <= abs_ts_p0;
        end
    end
`else
    assign abs_ts_p0 = '0;
`endif

    always_comb begin
        rec_p0          = '0;
        rec_p0.instr    = s_axis_tdata[INSTR_OFF +: INSTR_W];
        rec_p0.pc       = s_axis_tdata[PC_OFF +: XLEN];
        rec_p0.delta    = delta_p0;
        rec_p0.abs_ts   = abs_ts_p0;
        rec_p0.ovf      = s_axis_tdata[OVF_OFF +: NO_EVENTS];
        rec_p0.counters = counters_p0;
        rec_p0.last     = s_axis_tlast;
    end

    always_comb begin
        count_d = count_p1;
        if (push && !pop) begin
            count_d = count_p1 + 2'd1;
        end else if (pop && !push) begin
            count_d = count_p1 - 2'd1;
        end
    end

    always_comb begin
        frame_set  = 1'b0;
        beat_cnt_d = beat_cnt_p1;
        if (push) begin
            if (s_axis_tlast) begin
                beat_cnt_d = '0;
                if ((tlast_interval != 32'd0) && (beat_cnt_p1 + 32'd1 != tlast_interval) &&
                    (rec_p0.instr != WFI_INSTR)) begin
                    frame_set = 1'b1;
                end
            end else if ((tlast_interval != 32'd0) && (beat_cnt_p1 + 32'd1 == tlast_interval)) begin
                frame_set  = 1'b1;
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_p1 + 32'd1;
            end
        end
    end

    // ---- stage p1: head/skid registers and control state ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p1     <= 2'd0;
            vld_p1       <= 1'b0;
            tready_p1    <= 1'b1;
            pkt_count_p1 <= '0;
            beat_cnt_p1  <= '0;
            frame_err_p1 <= 1'b0;
        end else begin
            count_p1    <= count_d;
            vld_p1      <= (count_d != 2'd0);
            tready_p1   <= (count_d != 2'd2);
            beat_cnt_p1 <= beat_cnt_d;
            if (pop) begin
                pkt_count_p1 <= sat_inc(pkt_count_p1);
            end
            if (frame_set) begin
                frame_err_p1 <= 1'b1;
            end else if (clr_err) begin
                frame_err_p1 <= 1'b0;
            end
        end
    end

    // Head feeds the outputs directly; the skid slot only fills while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (push && ((count_p1 == 2'd0) || pop)) begin
                head_p1 <= rec_p0;
            end else if (pop && (count_p1 == 2'd2)) begin
                head_p1 <= skid_p1;
            end
            if (push && !pop && (count_p1 == 2'd1)) begin
                skid_p1 <= rec_p0;
            end
        end
    end

    assign s_axis_tready    = tready_p1;
    assign out_valid        = vld_p1;
    assign out_instr        = head_p1.instr;
    assign out_pc           = head_p1.pc;
    assign out_delta        = head_p1.delta;
    assign out_abs_ts       = head_p1.abs_ts;
    assign out_overflow_map = head_p1.ovf;
    assign out_counters     = head_p1.counters;
    assign out_last         = head_p1.last;
    assign pkt_count        = pkt_count_p1;
    assign frame_err        = frame_err_p1;

endmodule

// File: tb/tb_cms_trace_stream_receiver.sv
// Randomised self-checking bench for cms_trace_stream_receiver against a queue-based reference model.
module tb_cms_trace_stream_receiver;

    localparam int NE   = 39;
    localparam int CW   = 7;
    localparam int CNTS = NE * CW;
    localparam int DW   = CNTS + NE + 64 + 64 + 32;
    localparam logic [31:0] WFI = 32'h10500073;
`ifdef CMS_RX_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic            s_axis_tlast = 1'b0;
    logic [31:0]     tlast_interval = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_instr;
    logic [63:0]     out_pc;
    logic [63:0]     out_delta;
    logic [63:0]     out_abs_ts;
    logic [NE-1:0]   out_overflow_map;
    logic [CNTS-1:0] out_counters;
    logic            out_last;
    logic [31:0]     pkt_count;
    logic            frame_err;
    logic            clr_err = 1'b0;

    cms_trace_stream_receiver dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .tlast_interval(tlast_interval),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_delta(out_delta),
        .out_abs_ts(out_abs_ts), .out_overflow_map(out_overflow_map),
        .out_counters(out_counters), .out_last(out_last),
        .pkt_count(pkt_count), .frame_err(frame_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     instr;
        logic [63:0]     pc;
        logic [63:0]     delta;
        logic [63:0]     abs_ts;
        logic [NE-1:0]   ovf;
        logic [CNTS-1:0] cnt;
        logic            last;
    } rec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    rec_t        q[$];
    logic [63:0] m_abs;
    int unsigned m_beat;
    int unsigned m_pkt;
    logic        m_err;
    bit          pushed;
    bit          popped;

    // Current beat, counters held in logical order (event i at i*CW)
    logic [31:0]     b_instr;
    logic [63:0]     b_pc;
    logic [63:0]     b_delta;
    logic [NE-1:0]   b_ovf;
    logic [CNTS-1:0] b_cnt;
    logic            b_last;

    function automatic rec_t dut_rec();
        return {out_instr, out_pc, out_delta, out_abs_ts, out_overflow_map, out_counters, out_last};
    endfunction

    function automatic logic [DW-1:0] pack_beat();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < NE; i++) d[(NE-1-i)*CW +: CW] = b_cnt[i*CW +: CW];
        d[CNTS +: NE]           = b_ovf;
        d[CNTS+NE +: 64]        = b_pc;
        d[CNTS+NE+64 +: 64]     = b_delta;
        d[CNTS+NE+128 +: 32]    = b_instr;
        return d;
    endfunction

    task automatic rand_beat();
        logic [31:0] w;
        logic [63:0] t;
        b_instr = $urandom;
        b_pc    = {$urandom, $urandom};
        b_delta = {$urandom, $urandom};
        t       = {$urandom, $urandom};
        b_ovf   = t[NE-1:0];
        for (int k = 0; k < CNTS; k++) begin
            w = $urandom;
            b_cnt[k] = w[0];
        end
        b_last = 1'b0;
    endtask

    // One clock: drive at negedge, advance model at posedge, return at next negedge.
    task automatic step(input logic v, input logic rdy, input logic clr);
        rec_t e;
        logic set;
        s_axis_tvalid = v;
        s_axis_tdata  = pack_beat();
        s_axis_tlast  = b_last;
        out_ready     = rdy;
        clr_err       = clr;
        pushed = v && (q.size() < 2);
        popped = (q.size() != 0) && rdy;
        e = '{instr: b_instr, pc: b_pc, delta: b_delta, abs_ts: 64'd0, ovf: b_ovf, cnt: b_cnt, last: b_last};
        set = 1'b0;
        @(posedge clk);
        if (popped) begin
            q.delete(0);
            if (m_pkt != 32'hFFFF_FFFF) m_pkt++;
        end
        if (pushed) begin
            if (TS_EN) begin
                m_abs = m_abs + b_delta;
                e.abs_ts = m_abs;
            end
            if (b_last) begin
                if (tlast_interval != 0 && m_beat + 1 != tlast_interval && b_instr != WFI) set = 1'b1;
                m_beat = 0;
            end else begin
                m_beat++;
                if (tlast_interval != 0 && m_beat == tlast_interval) begin
                    set = 1'b1;
                    m_beat = 0;
                end
            end
            q.push_back(e);
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        out_ready = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_abs = '0; m_beat = 0; m_pkt = 0; m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b exp 1", s_axis_tready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt got %0d exp 0", pkt_count); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        checks++; if (dut_rec() !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", dut_rec()); end
    endtask

    task automatic test_single();
        do_reset();
        tlast_interval = 32'd0;
        rand_beat();
        b_delta = 64'd5; b_pc = 64'h8000_0000; b_instr = 32'h0000_0013;
        step(1'b1, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
        checks++; if (out_pc !== 64'h8000_0000) begin errors++; $display("FAIL single_pc got %h exp 80000000", out_pc); end
        checks++; if (out_delta !== 64'd5) begin errors++; $display("FAIL single_delta got %0d exp 5", out_delta); end
        checks++; if (out_abs_ts !== (TS_EN ? 64'd5 : 64'd0)) begin errors++; $display("FAIL single_abs got %0d exp %0d", out_abs_ts, TS_EN ? 5 : 0); end
        checks++; if (dut_rec() !== q[0]) begin errors++; $display("FAIL single_rec got %h exp %h", dut_rec(), q[0]); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt got %0d exp 1", pkt_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] deltas [4] = '{64'd1, 64'd1, 64'd3, 64'd2};
        logic [63:0] abs_e  [4] = '{64'd1, 64'd2, 64'd5, 64'd7};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rand_beat();
            b_delta = deltas[k];
            checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL b2b_tready[%0d] got %b exp 1", k, s_axis_tready); end
            step(1'b1, 1'b1, 1'b0);
            checks++; if (out_abs_ts !== (TS_EN ? abs_e[k] : 64'd0)) begin errors++; $display("FAIL b2b_abs[%0d] got %0d exp %0d", k, out_abs_ts, TS_EN ? abs_e[k] : 64'd0); end
            checks++; if (dut_rec() !== q[0]) begin errors++; $display("FAIL b2b_rec[%0d] got %h exp %h", k, dut_rec(), q[0]); end
        end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (pkt_count !== 32'd4) begin errors++; $display("FAIL b2b_pkt got %0d exp 4", pkt_count); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL b2b_tready_end got %b exp 1", s_axis_tready); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        do_reset();
        rand_beat();
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b0, 1'b0);
            if (pushed) begin sent++; rand_beat(); end
            checks++; if (s_axis_tready !== (sent < 2)) begin errors++; $display("FAIL bp_tready[%0d] got %b exp %b", c, s_axis_tready, sent < 2); end
            checks++; if (dut_rec() !== q[0]) begin errors++; $display("FAIL bp_stable[%0d] got %h exp %h", c, dut_rec(), q[0]); end
        end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", s_axis_tready); end
        for (int c = 0; c < 6; c++) begin
            step(sent < 3, 1'b1, 1'b0);
            if (pushed) begin sent++; rand_beat(); end
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL bp_valid[%0d] got %b exp %b", c, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (dut_rec() !== q[0]) begin errors++; $display("FAIL bp_order[%0d] got %h exp %h", c, dut_rec(), q[0]); end
            end
        end
        checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL bp_pkt got %0d exp 3", pkt_count); end
    endtask

    task automatic test_counter_order();
        do_reset();
        rand_beat();
        b_cnt = '0;
        b_cnt[0 +: CW]     = 7'h7F;
        b_cnt[38*CW +: CW] = 7'h01;
        step(1'b1, 1'b1, 1'b0);
        checks++; if (out_counters[0 +: CW] !== 7'h7F) begin errors++; $display("FAIL cnt_ev0 got %h exp 7f", out_counters[0 +: CW]); end
        checks++; if (out_counters[38*CW +: CW] !== 7'h01) begin errors++; $display("FAIL cnt_ev38 got %h exp 01", out_counters[38*CW +: CW]); end
        rand_beat();
        step(1'b1, 1'b1, 1'b0);
        checks++; if (out_counters !== q[0].cnt) begin errors++; $display("FAIL cnt_rand got %h exp %h", out_counters, q[0].cnt); end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_frame_err();
        // {valid, tlast, wfi, clr, expected frame_err}
        logic [4:0] tbl [19] = '{
            5'b10000, 5'b10000, 5'b10000, 5'b11000,
            5'b10000, 5'b11001, 5'b00010,
            5'b10000, 5'b11100,
            5'b10000, 5'b10000, 5'b10000, 5'b10001,
            5'b00010, 5'b10000, 5'b10000, 5'b10000, 5'b10011,
            5'b10010};
        do_reset();
        tlast_interval = 32'd4;
        for (int k = 0; k < 19; k++) begin
            rand_beat();
            b_last  = tbl[k][3];
            b_instr = tbl[k][2] ? WFI : 32'h0000_0013;
            step(tbl[k][4], 1'b1, tbl[k][1]);
            checks++; if (frame_err !== tbl[k][0]) begin errors++; $display("FAIL ferr[%0d] got %b exp %b", k, frame_err, tbl[k][0]); end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        tlast_interval = 32'd0;
        for (int k = 0; k < 4; k++) begin
            rand_beat();
            step(1'b1, k < 2, 1'b0);
        end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", s_axis_tready); end
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mid_pkt got %0d exp 0", pkt_count); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL mid_tready got %b exp 1", s_axis_tready); end
        rand_beat();
        step(1'b1, 1'b1, 1'b0);
        checks++; if (out_abs_ts !== (TS_EN ? b_delta : 64'd0)) begin errors++; $display("FAIL mid_abs got %h exp %h", out_abs_ts, TS_EN ? b_delta : 64'd0); end
        checks++; if (dut_rec() !== q[0]) begin errors++; $display("FAIL mid_rec got %h exp %h", dut_rec(), q[0]); end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic v, r, c;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) tlast_interval = $urandom_range(0, 5);
            rand_beat();
            b_last = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) b_instr = WFI;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            step(v, r, c);
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, out_valid, q.size() != 0); end
            checks++; if (s_axis_tready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_tready[%0d] got %b exp %b", n, s_axis_tready, q.size() < 2); end
            checks++; if (frame_err !== m_err) begin errors++; $display("FAIL rnd_ferr[%0d] got %b exp %b", n, frame_err, m_err); end
            checks++; if (pkt_count !== m_pkt) begin errors++; $display("FAIL rnd_pkt[%0d] got %0d exp %0d", n, pkt_count, m_pkt); end
            if (q.size() != 0) begin
                checks++; if (dut_rec() !== q[0]) begin errors++; $display("FAIL rnd_rec[%0d] got %h exp %h", n, dut_rec(), q[0]); end
            end
        end
    endtask

    initial begin
        rand_beat();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_counter_order();
        test_frame_err();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule

// File: doc/cms_trace_stream_receiver.md
Name: cms_trace_stream_receiver

Overview:
- AXI-Stream slave that sits at the consuming end of the continuous monitoring system's trace stream, e.g. an on-chip checker or a DMA bypass sink.
- Accepts packed trace packets and buffers them in a 2-entry skid FIFO.
- Unpacks each packet into instr, pc, clock delta, overflow map and per-event counters, and presents them on a valid/ready decoded-record port.
- Also reconstructs absolute timestamps and checks frame (tlast) integrity.

Parameters:
- XLEN, 64, PC width.
- INSTR_W, 32, instruction width.
- TS_W, 64, clock-delta and timestamp width.
- NO_EVENTS, 39, number of performance events.
- CNT_W, 7, width of each per-event counter.
- DATA_W, NO_EVENTS*CNT_W+NO_EVENTS+XLEN+TS_W+INSTR_W, stream width; derived localparam, not overridable.
- WFI_INSTR, 32'h10500073, encoding that legitimately terminates a frame early.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_axis_tvalid  in  1  stream beat valid
- s_axis_tready  out  1  stream beat accepted when high together with tvalid
- s_axis_tdata  in  DATA_W  packed packet
- s_axis_tlast  in  1  frame end
- tlast_interval  in  32  expected beats per frame
- out_valid  out  1  decoded record valid
- out_ready  in  1  downstream accepts record
- out_instr  out  INSTR_W  decoded instruction
- out_pc  out  XLEN  decoded PC
- out_delta  out  TS_W  clocks since previous write
- out_abs_ts  out  TS_W  reconstructed timestamp
- out_overflow_map  out  NO_EVENTS  counter overflow bits
- out_counters  out  NO_EVENTS*CNT_W  counters, event i at [i*CNT_W +: CNT_W]
- out_last  out  1  record closed a frame
- pkt_count  out  32  total records popped
- frame_err  out  1  sticky frame-length error
- clr_err  in  1  clears frame_err

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked by clk.
- Reset values:
  - s_axis_tready=1; out_valid=0.
  - All out_* data outputs, pkt_count, out_abs_ts and frame_err are 0.
  - Frame beat counter is 0; FIFO is empty.
- Packet layout, LSB first:
  - counters region [0 +: NO_EVENTS*CNT_W]: event 0 occupies the MOST significant CNT_W slot, so event i is at [(NO_EVENTS-1-i)*CNT_W +: CNT_W]. The receiver reverses the order so out_counters event i sits at [i*CNT_W].
  - overflow map: next NO_EVENTS bits.
  - pc: next XLEN bits.
  - delta: next TS_W bits.
  - instr: top INSTR_W bits.
- Input handshake:
  - Beat is pushed when s_axis_tvalid & s_axis_tready.
  - s_axis_tready = FIFO count < 2. It is a registered flag, with no combinational path from out_ready.
  - Push and pop in the same cycle with the FIFO full is not permitted; tready is already low in that case.
- Output handshake:
  - Head of FIFO is presented registered; out_valid=1 whenever the FIFO is non-empty.
  - Pop occurs on out_valid & out_ready.
  - Outputs remain stable while out_valid & ~out_ready.
- Latency: a beat accepted in cycle N appears on out_* in cycle N+1 if the FIFO was empty. Throughput is 1 record/cycle with out_ready held high.
- Timestamp:
  - At push, abs_ts_next = abs_ts_prev + delta, stored with the entry. Arithmetic is modulo 2^TS_W; wrap is silent.
  - The first record after reset gets out_abs_ts = delta.
- pkt_count increments on pop and saturates at 2^32-1.
- Frame check, on push:
  - beat counter increments; on a tlast beat it resets to 0.
  - If a tlast beat arrives with (counter+1) != tlast_interval and instr != WFI_INSTR, frame_err is set.
  - If the counter reaches tlast_interval without tlast, frame_err is set and the counter resets.
  - tlast_interval = 0 disables checking.
- frame_err: clr_err clears it. If clr_err coincides with a new error, the set wins.
- Reset mid-stream: FIFO is flushed, in-flight records are discarded, and all counts are cleared.

Optional Feature:
- Macro: CMS_RX_TIMESTAMP_EN.
- Defined: absolute timestamp accumulator is built as described.
- Undefined: accumulator logic is removed and out_abs_ts is tied to 0. All other behaviour is unchanged.

Test Plan:
- Single beat, delta=5, pc=0x80000000, instr=0x00000013, out_ready=1:
  - out_valid high in the next cycle.
  - out_pc=0x80000000, out_delta=5, out_abs_ts=5, pkt_count=1.
- Back-to-back 4 beats with deltas 1,1,3,2 and out_ready=1: out_abs_ts sequence is 1,2,5,7; tready stays 1 throughout.
- Backpressure:
  - out_ready=0 while 3 beats are offered: tready drops after 2 pushes; the third beat is held by the source.
  - Records stay stable while stalled.
  - With out_ready=1, order is preserved and none are lost.
- Counter ordering: event 0 slot=0x7F and event 38 slot=0x01 in the packet -> out_counters[0 +: 7]=0x7F and out_counters[38*7 +: 7]=0x01.
- Frame errors with tlast_interval=4:
  - tlast on beat 4 -> frame_err=0.
  - tlast on beat 2 with instr=0x00000013 -> frame_err=1.
  - clr_err, then tlast on beat 2 with instr=0x10500073 -> frame_err remains 0.
- Reset with 2 records buffered: after release, out_valid=0, pkt_count=0, tready=1, and the next beat is decoded with out_abs_ts=delta.
